// File: rtl/shift_reg_4b.sv
// shift_reg_4b: right-shift register with parallel load, zero-filled from the MSB
module shift_reg_4b #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             load,
  input  logic             ena,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);
  // reset beats load, load beats shift, otherwise hold
  always_ff @(posedge clk)
    q <= !areset ? RESET_VALUE : load ? data : ena ? {1'b0, q[WIDTH-1:1]} : q;
endmodule

// File: tb/tb_shift_reg_4b.sv
// tb_shift_reg_4b: directed vectors feed a scoreboard queue checked by an independent monitor
module tb_shift_reg_4b;
  typedef struct {
    logic [3:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       load = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] data = '0;
  logic [3:0] q;
  exp_t       sb[$];
  bit         done = 1'b0;
  int         checks = 0;
  int         fails = 0;

  shift_reg_4b #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
    .clk(clk), .areset(areset), .load(load), .ena(ena), .data(data), .q(q)
  );

  always #5 clk = ~clk;

  // drive one edge worth of controls and record what q must become after that edge
  task automatic step(input logic rn, input logic ld, input logic en, input logic [3:0] d,
                      input logic [3:0] exp, input string name, input bit glitch = 1'b0);
    @(negedge clk);
    areset = rn;
    load   = ld;
    ena    = en;
    data   = d;
    sb.push_back('{exp, name});
    if (glitch) begin
      areset = 1'b0;
      #2 areset = 1'b1;
    end
  endtask

  initial begin
    step(0, 1, 1, 4'b1111, 4'b0000, "reset_over_load");
    step(1, 0, 0, 4'b1111, 4'b0000, "reset_hold");
    step(1, 1, 0, 4'b1011, 4'b1011, "load");
    step(1, 0, 0, 4'b0000, 4'b1011, "hold1");
    step(1, 0, 0, 4'b0110, 4'b1011, "hold_data_ignored");
    step(1, 0, 1, 4'b0000, 4'b0101, "single_shift");
    step(1, 0, 0, 4'b0000, 4'b0101, "shift_hold");
    step(1, 1, 1, 4'b1100, 4'b1100, "load_over_ena");
    step(1, 0, 0, 4'b0000, 4'b1100, "collision_hold");
    step(1, 1, 0, 4'b1111, 4'b1111, "load_ones");
    step(1, 0, 1, 4'b1010, 4'b0111, "empty_shift1");
    step(1, 0, 1, 4'b0000, 4'b0011, "empty_shift2");
    step(1, 0, 1, 4'b0000, 4'b0001, "empty_shift3");
    step(1, 0, 1, 4'b0000, 4'b0000, "empty_shift4");
    step(1, 0, 1, 4'b0000, 4'b0000, "shift_zero");
    step(1, 1, 0, 4'b1010, 4'b1010, "load_1010");
    step(1, 0, 1, 4'b0000, 4'b0101, "mid_shift1");
    step(0, 0, 1, 4'b0000, 4'b0000, "reset_mid_shift");
    step(1, 1, 0, 4'b1001, 4'b1001, "load_1001");
    step(1, 0, 0, 4'b0000, 4'b1001, "reset_glitch_ignored", 1'b1);
    step(1, 0, 1, 4'b0000, 4'b0100, "shift_after_glitch");
    step(0, 0, 0, 4'b0000, 4'b0000, "reset_over_hold");
    done = 1'b1;
  end

  // monitor: q is presented every edge; compare it against the oldest pending expectation
  initial begin
    exp_t e;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (q !== e.exp) begin
          fails++;
          $display("FAIL %s: q=%b expected=%b", e.name, q, e.exp);
        end
      end
      if (done && sb.size() == 0) break;
    end
    if (!done || sb.size() != 0) begin
      fails++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/shift_reg_4b.md
Name: shift_reg_4b

Overview:
- Parameterised right-shift register with parallel load; default width 4 bits.
- Used as a small datapath/staging register: it captures a parallel word, then shifts it toward bit 0 one position per enabled cycle, zero-filling from the MSB.
- Single clock domain, fully synchronous, no combinational path from inputs to q.

Parameters:
- WIDTH, 4, register width in bits (legal range 2..64).
- RESET_VALUE, {WIDTH{1'b0}}, value q takes on reset.

Ports:
- clk  input  1  rising-edge clock; all state changes occur on this edge only.
- areset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk edge.
- load  input  1  parallel-load strobe, active-high.
- ena  input  1  shift enable, active-high.
- data  input  WIDTH  parallel load value.
- q  output  WIDTH  register contents, driven directly from flops.

Behaviour:
- All updates occur on the rising edge of clk. Priority order is strictly reset > load > ena > hold.
- Reset:
  - If areset==0 at the edge, q <= RESET_VALUE (all zeros by default).
  - Reset is synchronous: asserting areset between edges has no effect until the next edge.
  - Reset overrides load and ena in the same cycle, including mid-shift.
- Load:
  - Else if load==1, q <= data.
  - This applies whatever ena is; load wins when load and ena are both high.
- Shift:
  - Else if ena==1, q <= {1'b0, q[WIDTH-1:1]}: logical right shift by one.
  - Bit 0 is discarded; the MSB is filled with 0.
- Hold: otherwise q holds its value.
- Latency: q reflects the new value one edge after the control is sampled. There is no multi-cycle operation and no handshake.
- Boundaries:
  - After WIDTH consecutive shifts with no load, q==0.
  - Shifting q==0 keeps q==0.
  - data is ignored unless load==1.
- X handling: after reset, q must never be X provided inputs are known.
- No outputs other than q. No internal state beyond the WIDTH flops.

Test Plan:
- Reset: drive areset=0 for one edge with load=1, data=4'b1111, ena=1 -> q==4'b0000; release areset=1, load=0, ena=0 -> q holds 4'b0000.
- Load then hold: load=1, data=4'b1011 for one edge -> q==4'b1011; load=0, ena=0 for 2 edges -> q stays 4'b1011.
- Single shift: from q=4'b1011, ena=1 for one edge -> q==4'b0101; ena=0 -> q holds 4'b0101.
- Load/ena collision: from q=4'b0101, load=1, ena=1, data=4'b1100 -> q==4'b1100 (load priority, no shift); then load=0, ena=0 -> q holds 4'b1100.
- Shift to empty: load 4'b1111, then ena=1 for 5 edges -> q sequence 0111, 0011, 0001, 0000, 0000.
- Reset mid-operation: load 4'b1010, ena=1, assert areset=0 on the 2nd shift edge -> q==4'b0101 after the first shift, then 4'b0000; areset pulse applied between edges only, not spanning an edge -> no change in q.
